// File: rtl/wbu_arb.sv
// wbu_arb: writeback unit merging the in-order load/store result and the
// buffered out-of-order multiply/divide result onto one registered
// register-file write port.
module wbu_arb #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5,
  parameter int unsigned MdFifoDepth  = 2,
  parameter int unsigned OffWidth     = $clog2(DataWidth / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ldst_valid,
  input  logic                    ldst_memtoreg,
  input  logic [1:0]              ldst_load_size,
  input  logic                    ldst_load_unsigned,
  input  logic [OffWidth-1:0]     ldst_byte_off,
  input  logic [RegAddrWidth-1:0] ldst_addr_dst,
  input  logic [DataWidth-1:0]    ldst_alu_result,
  input  logic [DataWidth-1:0]    ldst_load_data,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [RegAddrWidth-1:0] md_addr_dst,
  input  logic [DataWidth-1:0]    md_result,
  output logic                    wbu_we,
  output logic [RegAddrWidth-1:0] wbu_addr_dst,
  output logic [DataWidth-1:0]    wbu_result,
  output logic                    wbu_md_pending,
  output logic                    wbu_stall
);

  localparam int unsigned PtrW = $clog2(MdFifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataWidth-1:0]    r_mem_data [MdFifoDepth];
  logic [RegAddrWidth-1:0] r_mem_addr [MdFifoDepth];
  logic [PtrW-1:0]         r_rd_ptr;
  logic [PtrW-1:0]         r_wr_ptr;
  logic [CntW-1:0]         r_count;
  logic                    r_we;
  logic [RegAddrWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_result;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_pipe;
  logic                    w_pop;
  logic                    w_bypass;
  logic                    w_push;
  logic [OffWidth-1:0]     w_sh_bytes;
  logic [6:0]              w_bits;
  logic [DataWidth-1:0]    w_shifted;
  logic [DataWidth-1:0]    w_mask;
  logic [DataWidth-1:0]    w_msb;
  logic                    w_sign;
  logic [DataWidth-1:0]    w_load;
  logic [DataWidth-1:0]    w_pipe_result;

  assign w_full   = (r_count == CntW'(MdFifoDepth));
  assign w_empty  = (r_count == '0);
  assign md_ready = !w_full;
  assign w_accept = md_valid && !w_full;
  assign w_pipe   = ldst_valid && (ldst_addr_dst != '0);
  assign w_pop    = !w_pipe && !w_empty;
  assign w_bypass = !w_pipe && w_empty && w_accept && (md_addr_dst != '0);
  assign w_push   = w_accept && (md_addr_dst != '0) && !w_bypass;

  assign wbu_we         = r_we;
  assign wbu_addr_dst   = r_addr;
  assign wbu_result     = r_result;
  assign wbu_md_pending = !w_empty;
  assign wbu_stall      = w_full;

  // Load lane selection and field width; sign bit found via the mask MSB
  // so the field width can be a runtime value without variable indexing.
  always_comb begin
    w_sh_bytes = '0;
    w_bits     = 7'(DataWidth);
    unique case (ldst_load_size)
      2'b00: begin
        w_sh_bytes = ldst_byte_off;
        w_bits     = 7'd8;
      end
      2'b01: begin
        w_sh_bytes = ldst_byte_off & ~OffWidth'(1);
        w_bits     = 7'd16;
      end
      2'b10: begin
        if (DataWidth == 64) begin
          w_sh_bytes = ldst_byte_off & ~OffWidth'(3);
          w_bits     = 7'd32;
        end
      end
      default: ;
    endcase
    w_shifted     = ldst_load_data >> {w_sh_bytes, 3'b000};
    w_mask        = {DataWidth{1'b1}} >> (7'(DataWidth) - w_bits);
    w_msb         = w_mask & ~(w_mask >> 1);
    w_sign        = |(w_shifted & w_msb);
    w_load        = (w_shifted & w_mask) |
                    ((!ldst_load_unsigned && w_sign) ? ~w_mask : '0);
    w_pipe_result = ldst_memtoreg ? w_load : ldst_alu_result;
  end

  // FIFO pointers/occupancy and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_result <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      r_we     <= w_pipe || w_pop || w_bypass;
      r_addr   <= '0;
      r_result <= '0;
      if (w_pipe) begin
        r_addr   <= ldst_addr_dst;
        r_result <= w_pipe_result;
      end else if (w_pop) begin
        r_addr   <= r_mem_addr[r_rd_ptr];
        r_result <= r_mem_data[r_rd_ptr];
      end else if (w_bypass) begin
        r_addr   <= md_addr_dst;
        r_result <= md_result;
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= md_addr_dst;
      r_mem_data[r_wr_ptr] <= md_result;
    end
  end

endmodule

// File: tb/tb_wbu_arb.sv
// Testbench for wbu_arb at default parameters (DataWidth=32, depth 2).
module tb_wbu_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ldst_valid = 1'b0;
  logic        ldst_memtoreg = 1'b0;
  logic [1:0]  ldst_load_size = 2'b00;
  logic        ldst_load_unsigned = 1'b0;
  logic [1:0]  ldst_byte_off = 2'b00;
  logic [4:0]  ldst_addr_dst = '0;
  logic [31:0] ldst_alu_result = '0;
  logic [31:0] ldst_load_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_addr_dst = '0;
  logic [31:0] md_result = '0;
  logic        wbu_we;
  logic [4:0]  wbu_addr_dst;
  logic [31:0] wbu_result;
  logic        wbu_md_pending;
  logic        wbu_stall;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  wbu_arb #(.DataWidth(32), .RegAddrWidth(5), .MdFifoDepth(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ldst_valid(ldst_valid), .ldst_memtoreg(ldst_memtoreg),
    .ldst_load_size(ldst_load_size), .ldst_load_unsigned(ldst_load_unsigned),
    .ldst_byte_off(ldst_byte_off), .ldst_addr_dst(ldst_addr_dst),
    .ldst_alu_result(ldst_alu_result), .ldst_load_data(ldst_load_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr_dst(md_addr_dst),
    .md_result(md_result), .wbu_we(wbu_we), .wbu_addr_dst(wbu_addr_dst),
    .wbu_result(wbu_result), .wbu_md_pending(wbu_md_pending),
    .wbu_stall(wbu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        lv;
    logic        m2r;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  addr;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        mv;
    logic [4:0]  maddr;
    logic [31:0] mres;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_res;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ldst_valid = 1'b0;
    md_valid   = 1'b0;
  endtask

  task automatic set_ldst_alu(input logic [4:0] a, input logic [31:0] v);
    ldst_valid = 1'b1; ldst_memtoreg = 1'b0;
    ldst_addr_dst = a; ldst_alu_result = v;
  endtask

  task automatic set_md(input logic [4:0] a, input logic [31:0] v);
    md_valid = 1'b1; md_addr_dst = a; md_result = v;
  endtask

  function automatic vec_t mk(string n, logic lv, logic m2r, logic [1:0] sz, logic u,
                              logic [1:0] o, logic [4:0] a, logic [31:0] alu, logic [31:0] ld,
                              logic mv, logic [4:0] ma, logic [31:0] mr,
                              logic ew, logic [4:0] ea, logic [31:0] er, logic ep);
    vec_t v;
    v.name = n; v.lv = lv; v.m2r = m2r; v.size = sz; v.uns = u; v.off = o;
    v.addr = a; v.alu = alu; v.ld = ld; v.mv = mv; v.maddr = ma; v.mres = mr;
    v.e_we = ew; v.e_addr = ea; v.e_res = er; v.e_pend = ep;
    return v;
  endfunction

  initial begin
    // Single-cycle vectors, each starting and ending with an empty FIFO.
    vecs.push_back(mk("ld_b2_s",  1,1,2'b00,0,2'd2,5,0,32'h8899AABB, 0,0,0, 1,5,32'hFFFFFF99,0));
    vecs.push_back(mk("ld_b2_u",  1,1,2'b00,1,2'd2,5,0,32'h8899AABB, 0,0,0, 1,5,32'h00000099,0));
    vecs.push_back(mk("ld_h2_s",  1,1,2'b01,0,2'd2,5,0,32'h8899AABB, 0,0,0, 1,5,32'hFFFF8899,0));
    vecs.push_back(mk("ld_w",     1,1,2'b10,0,2'd0,5,0,32'h8899AABB, 0,0,0, 1,5,32'h8899AABB,0));
    vecs.push_back(mk("ld_b0_u",  1,1,2'b00,1,2'd0,6,0,32'h8899AABB, 0,0,0, 1,6,32'h000000BB,0));
    vecs.push_back(mk("ld_b3_s",  1,1,2'b00,0,2'd3,6,0,32'h8899AABB, 0,0,0, 1,6,32'hFFFFFF88,0));
    vecs.push_back(mk("ld_b1_s+", 1,1,2'b00,0,2'd1,6,0,32'h11227344, 0,0,0, 1,6,32'h00000073,0));
    vecs.push_back(mk("ld_h0_u",  1,1,2'b01,1,2'd0,9,0,32'h8899AABB, 0,0,0, 1,9,32'h0000AABB,0));
    vecs.push_back(mk("ld_h3_s",  1,1,2'b01,0,2'd3,9,0,32'h8899AABB, 0,0,0, 1,9,32'hFFFF8899,0));
    vecs.push_back(mk("ld_h0_s+", 1,1,2'b01,0,2'd0,9,0,32'h80007FFF, 0,0,0, 1,9,32'h00007FFF,0));
    vecs.push_back(mk("ld_dbl",   1,1,2'b11,0,2'd1,9,0,32'h8899AABB, 0,0,0, 1,9,32'h8899AABB,0));
    vecs.push_back(mk("alu",      1,0,2'b00,0,2'd0,31,32'hDEADBEEF,32'h1, 0,0,0, 1,31,32'hDEADBEEF,0));
    vecs.push_back(mk("bypass",   0,0,2'b00,0,2'd0,0,0,0, 1,7,32'h1234, 1,7,32'h1234,0));
    vecs.push_back(mk("ldst_x0",  1,0,2'b00,0,2'd0,0,32'h55,0, 0,0,0, 0,0,0,0));
    vecs.push_back(mk("md_x0",    0,0,2'b00,0,2'd0,0,0,0, 1,0,32'h77, 0,0,0,0));
    vecs.push_back(mk("x0_both",  1,0,2'b00,0,2'd0,0,32'h55,0, 1,0,32'h66, 0,0,0,0));

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_we", 32'(wbu_we), 32'd0);
    check("rst_addr", 32'(wbu_addr_dst), 32'd0);
    check("rst_result", wbu_result, 32'd0);
    check("rst_pending", 32'(wbu_md_pending), 32'd0);
    check("rst_stall", 32'(wbu_stall), 32'd0);
    check("rst_md_ready", 32'(md_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      ldst_valid = vecs[i].lv; ldst_memtoreg = vecs[i].m2r;
      ldst_load_size = vecs[i].size; ldst_load_unsigned = vecs[i].uns;
      ldst_byte_off = vecs[i].off; ldst_addr_dst = vecs[i].addr;
      ldst_alu_result = vecs[i].alu; ldst_load_data = vecs[i].ld;
      md_valid = vecs[i].mv; md_addr_dst = vecs[i].maddr; md_result = vecs[i].mres;
      tick();
      check({vecs[i].name, "_we"}, 32'(wbu_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check({vecs[i].name, "_addr"}, 32'(wbu_addr_dst), 32'(vecs[i].e_addr));
        check({vecs[i].name, "_res"}, wbu_result, vecs[i].e_res);
      end
      check({vecs[i].name, "_pend"}, 32'(wbu_md_pending), 32'(vecs[i].e_pend));
      check({vecs[i].name, "_ready"}, 32'(md_ready), 32'd1);
    end
    idle_inputs();
    tick();
    check("idle_we", 32'(wbu_we), 32'd0);

    // Collision: pipeline wins, md result buffered then written.
    set_ldst_alu(5'd3, 32'hA);
    set_md(5'd4, 32'hB);
    tick();
    check("col_we1", 32'(wbu_we), 32'd1);
    check("col_addr1", 32'(wbu_addr_dst), 32'd3);
    check("col_res1", wbu_result, 32'hA);
    check("col_pend1", 32'(wbu_md_pending), 32'd1);
    idle_inputs();
    tick();
    check("col_we2", 32'(wbu_we), 32'd1);
    check("col_addr2", 32'(wbu_addr_dst), 32'd4);
    check("col_res2", wbu_result, 32'hB);
    check("col_pend2", 32'(wbu_md_pending), 32'd0);
    tick();
    check("col_we3", 32'(wbu_we), 32'd0);

    // Full/stall: two accepts fill the FIFO, third offer held, then in-order drain.
    set_ldst_alu(5'd1, 32'h101);
    set_md(5'd8, 32'h800);
    tick();
    check("full_ready1", 32'(md_ready), 32'd1);
    check("full_pend1", 32'(wbu_md_pending), 32'd1);
    set_ldst_alu(5'd2, 32'h102);
    set_md(5'd9, 32'h900);
    tick();
    check("full_ready2", 32'(md_ready), 32'd0);
    check("full_stall2", 32'(wbu_stall), 32'd1);
    check("full_addr2", 32'(wbu_addr_dst), 32'd2);
    set_md(5'd10, 32'hA00);
    ldst_valid = 1'b0;
    tick();
    check("drain_addr8", 32'(wbu_addr_dst), 32'd8);
    check("drain_res8", wbu_result, 32'h800);
    check("drain_stall8", 32'(wbu_stall), 32'd0);
    tick();
    check("drain_addr9", 32'(wbu_addr_dst), 32'd9);
    check("drain_res9", wbu_result, 32'h900);
    check("drain_pend9", 32'(wbu_md_pending), 32'd1);
    md_valid = 1'b0;
    tick();
    check("drain_we10", 32'(wbu_we), 32'd1);
    check("drain_addr10", 32'(wbu_addr_dst), 32'd10);
    check("drain_res10", wbu_result, 32'hA00);
    check("drain_pend10", 32'(wbu_md_pending), 32'd0);
    tick();
    check("drain_done_we", 32'(wbu_we), 32'd0);

    // md result to x0 while entries are buffered: occupancy unchanged.
    set_ldst_alu(5'd1, 32'h1);
    set_md(5'd12, 32'hC);
    tick();
    set_md(5'd0, 32'hD);
    tick();
    check("x0_keep_pend", 32'(wbu_md_pending), 32'd1);
    check("x0_keep_stall", 32'(wbu_stall), 32'd0);
    idle_inputs();
    tick();
    check("x0_keep_addr", 32'(wbu_addr_dst), 32'd12);
    check("x0_keep_pend2", 32'(wbu_md_pending), 32'd0);
    tick();
    check("x0_keep_we", 32'(wbu_we), 32'd0);

    // Reset mid-operation with a full FIFO.
    set_ldst_alu(5'd1, 32'h1);
    set_md(5'd11, 32'hB0);
    tick();
    set_md(5'd12, 32'hC0);
    tick();
    check("mid_stall_pre", 32'(wbu_stall), 32'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("mid_we", 32'(wbu_we), 32'd0);
    check("mid_result", wbu_result, 32'd0);
    check("mid_pend", 32'(wbu_md_pending), 32'd0);
    check("mid_stall", 32'(wbu_stall), 32'd0);
    check("mid_ready", 32'(md_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_we", 32'(wbu_we), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/wbu_arb.md
# wbu_arb

Parametrised writeback unit with a registered write port. It merges two result sources onto the single register-file write port:
- the in-order load/store-stage result (ALU result, or load data aligned and sign/zero-extended here);
- the out-of-order long-latency multiply/divide result, buffered in a small FIFO.

It sits between the load/store stage and the register file, and feeds the hazard unit with pending/stall status.

## Interface
- DataWidth, 32, datapath width; 32 or 64 only
- RegAddrWidth, 5, destination register address width
- MdFifoDepth, 2, multiply/divide result FIFO entries; power of two, ≥2
- OffWidth, $clog2(DataWidth/8), derived; byte-offset width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ldst_valid  in  1  load/store stage carries a register-writing instruction
- ldst_memtoreg  in  1  1: write load data; 0: write ALU result
- ldst_load_size  in  2  00 byte, 01 half, 10 word, 11 double (double legal only when DataWidth=64; otherwise treated as word)
- ldst_load_unsigned  in  1  1: zero-extend; 0: sign-extend
- ldst_byte_off  in  OffWidth  byte address offset of the load
- ldst_addr_dst  in  RegAddrWidth  pipeline destination register
- ldst_alu_result  in  DataWidth  ALU result
- ldst_load_data  in  DataWidth  raw aligned memory word
- md_valid  in  1  multiply/divide result offered
- md_ready  out  1  result accepted this cycle when md_valid & md_ready
- md_addr_dst  in  RegAddrWidth  multiply/divide destination register
- md_result  in  DataWidth  multiply/divide result
- wbu_we  out  1  register-file write enable
- wbu_addr_dst  out  RegAddrWidth  write address
- wbu_result  out  DataWidth  write data
- wbu_md_pending  out  1  FIFO non-empty
- wbu_stall  out  1  FIFO full; hazard unit must hold ldst_valid low

## Operation
Load formatting (combinational, pipeline source only):
- Byte: lane ldst_byte_off.
- Half: lane ldst_byte_off[OffWidth-1:1]; bit 0 ignored.
- Word: lane ldst_byte_off[OffWidth-1:2] for DataWidth=64; whole word for DataWidth=32.
- Double: whole word.
- Extension: ldst_load_unsigned=1 zero-extends to DataWidth; 0 replicates the MSB of the selected field.

FIFO:
- md_ready = !full, computed from registered occupancy only; no combinational path from md_valid.
- An accepted result whose md_addr_dst=0 is discarded and never stored.

Per-cycle write selection, in priority order:
1. P (pipeline write): ldst_valid=1 and ldst_addr_dst≠0. Write the pipeline result. A pipeline write to x0 is dropped and counts as no P.
2. Not P, FIFO non-empty: pop the head and write it. Any md result accepted this cycle is pushed behind it.
3. Not P, FIFO empty, md accepted with nonzero address: write the md result directly (bypass); it is not stored.
4. Otherwise: no write.

FIFO occupancy update:
- Accept without pop: +1.
- Pop without accept: −1.
- Accept and pop in the same cycle: unchanged.
- Accepted results that are bypassed or discarded (x0) do not change occupancy.
- Entries leave the FIFO in order. Read and write pointers wrap modulo MdFifoDepth.

Status outputs:
- wbu_stall = full. Upstream keeps ldst_valid low while wbu_stall=1, which guarantees the FIFO drains.
- If ldst_valid arrives anyway, the pipeline still wins. Behaviour is otherwise undefined and not verified.

Reset (rst_n low, asynchronous):
- FIFO emptied.
- wbu_we=0, wbu_addr_dst=0, wbu_result=0.
- wbu_md_pending=0, wbu_stall=0, md_ready=1.
- Reset mid-operation discards all buffered results.

## Timing
- wbu_we, wbu_addr_dst and wbu_result are registered: a selection made in cycle N is driven in cycle N+1 for exactly one cycle.
- Latency from ldst inputs or a bypassed md handshake to the register-file write: 1 cycle.
- FIFO entry: pushed at edge N, earliest pop decision in cycle N+1, earliest output in cycle N+2.
- wbu_md_pending, wbu_stall and md_ready reflect occupancy after the most recent edge.

## Test plan
- Load formatting, DataWidth=32: ldst_valid=1, memtoreg=1, addr 5, load_data 0x8899AABB.
  - Byte, off 2, signed → cycle N+1: we=1, addr 5, result 0xFFFFFF99.
  - Same, unsigned → 0x00000099.
  - Half, off 2, signed → 0xFFFF8899.
  - Word → 0x8899AABB.
- Bypass: FIFO empty, ldst_valid=0, md_valid=1, addr 7, result 0x1234 → next cycle we=1, addr 7, result 0x1234; wbu_md_pending stays 0.
- Collision: ldst writes x3 (ALU 0xA) while md offers x4 (0xB).
  - Cycle N+1: write x3/0xA; wbu_md_pending=1.
  - ldst_valid=0 in cycle N+1 → cycle N+2: write x4/0xB; pending returns to 0.
- Full/stall, depth 2: ldst_valid held 1 to nonzero addresses; md offers x8, x9, x10.
  - After two accepts: md_ready=0, wbu_stall=1; x10 held by the md unit.
  - Drop ldst_valid → x8 written, then x9, then x10, in order; no results lost.
- x0 handling: ldst_valid=1, addr 0 → no write. md result to x0 → accepted and discarded; wbu_we=0 and occupancy unchanged.
- Reset mid-operation: FIFO holding 2 entries, rst_n pulsed low → we=0, result 0, pending=0, stall=0, md_ready=1 immediately; no stale writes after release.
